// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: commit-side bundle between the write-back stage and the
// CP0 register file.
//   master : write-back stage (drives requests, TLB read data, interrupt lines)
//   slave  : cp0_regfile (drives read data, exported registers, int_req)
// Parameter IDX_W: width of the TLB Index field.
interface cp0_regfile_if #(
    parameter int IDX_W = 4
);
    // exception / eret commit
    logic             wb_ex;
    logic             wb_bd;
    logic [4:0]       wb_excode;
    logic [31:0]      wb_pc;
    logic [31:0]      wb_badvaddr;
    logic             eret;
    logic [5:0]       ext_int_in;
    // mtc0 / mfc0
    logic [7:0]       cp0_addr;
    logic             mtc0_we;
    logic [31:0]      cp0_wdata;
    logic [31:0]      cp0_rdata;
    // TLB instructions and read-port data
    logic             tlbp;
    logic             tlbr;
    logic             tlbwi;
    logic             s1_found;
    logic [IDX_W-1:0] s1_index;
    logic [18:0]      r_vpn2;
    logic [7:0]       r_asid;
    logic             r_g;
    logic [19:0]      r_pfn0;
    logic [2:0]       r_c0;
    logic             r_d0;
    logic             r_v0;
    logic [19:0]      r_pfn1;
    logic [2:0]       r_c1;
    logic             r_d1;
    logic             r_v1;
    // exported state
    logic [31:0]      cp0_status;
    logic [31:0]      cp0_cause;
    logic [31:0]      cp0_epc;
    logic [31:0]      cp0_entryhi;
    logic [31:0]      cp0_entrylo0;
    logic [31:0]      cp0_entrylo1;
    logic [31:0]      cp0_index;
    logic             int_req;

    modport master (
        output wb_ex, wb_bd, wb_excode, wb_pc, wb_badvaddr, eret, ext_int_in,
        output cp0_addr, mtc0_we, cp0_wdata,
        output tlbp, tlbr, tlbwi, s1_found, s1_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
        output r_pfn1, r_c1, r_d1, r_v1,
        input  cp0_rdata, cp0_status, cp0_cause, cp0_epc, cp0_entryhi,
        input  cp0_entrylo0, cp0_entrylo1, cp0_index, int_req
    );

    modport slave (
        input  wb_ex, wb_bd, wb_excode, wb_pc, wb_badvaddr, eret, ext_int_in,
        input  cp0_addr, mtc0_we, cp0_wdata,
        input  tlbp, tlbr, tlbwi, s1_found, s1_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
        input  r_pfn1, r_c1, r_d1, r_v1,
        output cp0_rdata, cp0_status, cp0_cause, cp0_epc, cp0_entryhi,
        output cp0_entrylo0, cp0_entrylo1, cp0_index, int_req
    );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 architectural state for the commit stage. Handles
// mtc0/mfc0, exception entry, eret, tlbp/tlbr, the Count/Compare timer and
// interrupt-pending logic, and exports the registers used by fetch redirect
// and the TLB write port.
// Ports:
//   clk, reset : core clock, asynchronous active-high reset
//   bus        : cp0_regfile_if.slave (requests in, register values out)
// Optional: define CP0_CONFIG_EN to map read-only Config(16,0)/Config1(16,1).
module cp0_regfile #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input logic           clk,
    input logic           reset,
    cp0_regfile_if.slave  bus
);
    // {rd, sel} addresses
    localparam logic [7:0] A_INDEX = {5'd0, 3'd0}, A_LO0 = {5'd2, 3'd0},
                           A_LO1 = {5'd3, 3'd0}, A_BADV = {5'd8, 3'd0},
                           A_COUNT = {5'd9, 3'd0}, A_HI = {5'd10, 3'd0},
                           A_CMP = {5'd11, 3'd0}, A_STATUS = {5'd12, 3'd0},
                           A_CAUSE = {5'd13, 3'd0}, A_EPC = {5'd14, 3'd0},
                           A_CFG = {5'd16, 3'd0}, A_CFG1 = {5'd16, 3'd1};
    localparam logic [31:0] CONFIG_VAL  = 32'h8000_0000;
    localparam logic [31:0] CONFIG1_VAL = {1'b0, 6'(TLBNUM - 1), 25'b0};

    logic [7:0]       status_im;
    logic             status_exl, status_ie;
    logic             cause_bd, cause_ti;
    logic [5:0]       cause_ip_hw;
    logic [1:0]       cause_ip_sw;
    logic [4:0]       cause_exc;
    logic [31:0]      epc, badvaddr, count, compare;
    logic             tick;
    logic [18:0]      hi_vpn2;
    logic [7:0]       hi_asid;
    logic [25:0]      lo0, lo1;
    logic             index_p;
    logic [IDX_W-1:0] index_idx;

    logic [31:0] wd;
    assign wd = bus.cp0_wdata;

    function automatic logic wr(input logic [7:0] a);
        return bus.mtc0_we && (bus.cp0_addr == a);
    endfunction

    // address-error class codes update BadVAddr; TLB-class codes also EntryHi
    logic ex_addr, ex_tlb;
    assign ex_addr = (bus.wb_excode >= 5'h01) && (bus.wb_excode <= 5'h05);
    assign ex_tlb  = (bus.wb_excode >= 5'h01) && (bus.wb_excode <= 5'h03);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_im   <= '0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_ti    <= 1'b0;
            cause_ip_hw <= '0;
            cause_ip_sw <= '0;
            cause_exc   <= '0;
            epc         <= '0;
            badvaddr    <= '0;
            count       <= '0;
            compare     <= '0;
            tick        <= 1'b0;
            hi_vpn2     <= '0;
            hi_asid     <= '0;
            lo0         <= '0;
            lo1         <= '0;
            index_p     <= 1'b0;
            index_idx   <= '0;
        end else begin
            // Status
            if (bus.wb_ex)            status_exl <= 1'b1;
            else if (bus.eret)        status_exl <= 1'b0;
            else if (wr(A_STATUS))    {status_im, status_exl, status_ie} <= {wd[15:8], wd[1], wd[0]};

            // Cause
            if (bus.wb_ex) begin
                cause_exc <= bus.wb_excode;
                if (!status_exl) cause_bd <= bus.wb_bd;
            end else if (wr(A_CAUSE)) begin
                cause_ip_sw <= wd[9:8];
            end
            cause_ip_hw <= bus.ext_int_in;
            // a Compare write clears TI even if the match fires this cycle
            if (wr(A_CMP))               cause_ti <= 1'b0;
            else if (count == compare)   cause_ti <= 1'b1;

            // EPC: nested exceptions keep the original return address
            if (bus.wb_ex && !status_exl) epc <= bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
            else if (!bus.wb_ex && wr(A_EPC)) epc <= wd;

            if (bus.wb_ex && ex_addr) badvaddr <= bus.wb_badvaddr;

            // Timer: Count advances every other cycle
            tick <= ~tick;
            if (wr(A_COUNT))  count <= wd;
            else if (tick)    count <= count + 32'd1;
            if (wr(A_CMP))    compare <= wd;

            // EntryHi
            if (bus.wb_ex && ex_tlb)  hi_vpn2 <= bus.wb_badvaddr[31:13];
            else if (bus.tlbr)        hi_vpn2 <= bus.r_vpn2;
            else if (wr(A_HI))        hi_vpn2 <= wd[31:13];
            if (bus.tlbr)             hi_asid <= bus.r_asid;
            else if (wr(A_HI))        hi_asid <= wd[7:0];

            // EntryLo0/1
            if (bus.tlbr)        lo0 <= {bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_g};
            else if (wr(A_LO0))  lo0 <= wd[25:0];
            if (bus.tlbr)        lo1 <= {bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1, bus.r_g};
            else if (wr(A_LO1))  lo1 <= wd[25:0];

            // Index: P only from tlbp; a probe miss keeps the old index bits
            if (bus.tlbp)                        index_p <= ~bus.s1_found;
            if (bus.tlbp && bus.s1_found)        index_idx <= bus.s1_index;
            else if (!bus.tlbp && wr(A_INDEX))   index_idx <= wd[IDX_W-1:0];
        end
    end

    assign bus.cp0_status   = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
    // IP7 doubles as the timer interrupt
    assign bus.cp0_cause    = {cause_bd, cause_ti, 14'b0, cause_ip_hw[5] | cause_ti,
                               cause_ip_hw[4:0], cause_ip_sw, 1'b0, cause_exc, 2'b0};
    assign bus.cp0_epc      = epc;
    assign bus.cp0_entryhi  = {hi_vpn2, 5'b0, hi_asid};
    assign bus.cp0_entrylo0 = {6'b0, lo0};
    assign bus.cp0_entrylo1 = {6'b0, lo1};
    assign bus.cp0_index    = {index_p, {(31 - IDX_W){1'b0}}, index_idx};
    assign bus.int_req      = (|(bus.cp0_cause[15:8] & status_im)) & status_ie & ~status_exl;

    always_comb begin
        bus.cp0_rdata = 32'h0;
        case (bus.cp0_addr)
            A_INDEX:  bus.cp0_rdata = bus.cp0_index;
            A_LO0:    bus.cp0_rdata = bus.cp0_entrylo0;
            A_LO1:    bus.cp0_rdata = bus.cp0_entrylo1;
            A_BADV:   bus.cp0_rdata = badvaddr;
            A_COUNT:  bus.cp0_rdata = count;
            A_HI:     bus.cp0_rdata = bus.cp0_entryhi;
            A_CMP:    bus.cp0_rdata = compare;
            A_STATUS: bus.cp0_rdata = bus.cp0_status;
            A_CAUSE:  bus.cp0_rdata = bus.cp0_cause;
            A_EPC:    bus.cp0_rdata = epc;
`ifdef CP0_CONFIG_EN
            A_CFG:    bus.cp0_rdata = CONFIG_VAL;
            A_CFG1:   bus.cp0_rdata = CONFIG1_VAL;
`endif
            default:  bus.cp0_rdata = 32'h0;
        endcase
    end

    // tlbwi needs no CP0 update; the TLB samples the exported registers
`ifdef CP0_CONFIG_EN
    logic unused_sig;
    assign unused_sig = &{1'b0, bus.tlbwi};
`else
    logic unused_sig;
    assign unused_sig = &{1'b0, bus.tlbwi, CONFIG_VAL, CONFIG1_VAL, A_CFG, A_CFG1};
`endif
endmodule
